i2c_target: RTL

I2C target (responder) that sits opposite the I2C master on the same bus, clocked from the system clock `clk_in`. It oversamples SCL/SDA and detects START/STOP. It matches a 7-bit address, ACKs, and delivers written bytes on a byte-strobe interface. It serves reads from a byte-request interface by driving SDA open-drain.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_input_sync.sv | 40 ++++
 rtl/i2c_target.sv | 137 +++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C target and master.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} i2c_state_t;
endpackage

// File: rtl/i2c_input_sync.sv
// i2c_input_sync: 2-flop synchronizer with rise/fall pulses; I2C_TARGET_FILTER_EN adds a
// FILTER_LEN-cycle stability filter. Idles high so reset never fakes a bus edge.
module i2c_input_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_in,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic prev;
    always_ff @(posedge clk_in or negedge resetn)
        if (!resetn) sync <= 2'b11;
        else sync <= {sync[0], din};
`ifdef I2C_TARGET_FILTER_EN
    logic [3:0] cnt;
    always_ff @(posedge clk_in or negedge resetn)
        if (!resetn) begin
            level <= 1'b1;
            cnt <= '0;
        end else if (sync[1] == level) cnt <= '0;
        else if (cnt == 4'(FILTER_LEN - 1)) begin
            level <= sync[1];
            cnt <= '0;
        end else cnt <= cnt + 4'd1;
`else
    assign level = sync[1];
`endif
    always_ff @(posedge clk_in or negedge resetn)
        if (!resetn) prev <= 1'b1;
        else prev <= level;
    assign rise = level & ~prev;
    assign fall = ~level & prev;
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be within 1..15");
    end
endmodule

// File: rtl/i2c_target.sv
// i2c_target: oversampling I2C target with write byte-strobe and read byte-request interfaces.
// Define I2C_TARGET_FILTER_EN to glitch-filter SCL/SDA for FILTER_LEN cycles.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
    parameter int FILTER_LEN = 3
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);
    logic scl_s, scl_r, scl_f, sda_s, sda_r, sda_f;
    logic start, stop, addr_hit, full, rw, ack;
    logic [2:0] cnt;
    logic [7:0] sh;
    i2c_state_t state;

    i2c_input_sync #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk_in(clk_in), .resetn(resetn), .din(scl_in), .level(scl_s), .rise(scl_r), .fall(scl_f)
    );
    i2c_input_sync #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk_in(clk_in), .resetn(resetn), .din(sda_in), .level(sda_s), .rise(sda_r), .fall(sda_f)
    );

    assign start = scl_s & sda_f;
    assign stop = scl_s & sda_r;
    assign addr_hit = sh[7:1] == TARGET_ADDR && sh[7:1] != '0;
    // A byte is fetched in the same cycle it is loaded, so the request is combinational.
    assign tx_req = scl_f & ((state == ADDR_ACK && rw == I2C_RD) || (state == RD_ACK && ack == I2C_ACK));

    always_ff @(posedge clk_in or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            full <= 1'b0;
            rw <= I2C_WR;
            ack <= I2C_NACK;
            sda_oe <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            start_det <= 1'b0;
            stop_det <= 1'b0;
            busy <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            start_det <= 1'b0;
            stop_det <= 1'b0;
            if (start) begin
                state <= ADDR;
                cnt <= '0;
                full <= 1'b0;
                sda_oe <= 1'b0;
                busy <= 1'b0;
                start_det <= 1'b1;
            end else if (stop) begin
                state <= IDLE;
                full <= 1'b0;
                sda_oe <= 1'b0;
                busy <= 1'b0;
                stop_det <= 1'b1;
            end else
                case (state)
                    ADDR, WR_BYTE:
                        if (scl_r) begin
                            sh <= {sh[6:0], sda_s};
                            cnt <= cnt + 3'd1;
                            full <= cnt == 3'd7;
                            if (state == WR_BYTE && cnt == 3'd7) begin
                                rx_data <= {sh[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        // full marks the fall that ends the 8th bit, not the one after START
                        end else if (scl_f && full) begin
                            full <= 1'b0;
                            if (state == WR_BYTE) begin
                                state <= WR_ACK;
                                sda_oe <= 1'b1;
                            end else if (addr_hit) begin
                                state <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy <= 1'b1;
                                rw <= sh[0];
                            end else state <= IGNORE;
                        end
                    ADDR_ACK:
                        if (scl_f) begin
                            cnt <= '0;
                            if (rw == I2C_WR) begin
                                state <= WR_BYTE;
                                sda_oe <= 1'b0;
                            end else begin
                                state <= RD_BYTE;
                                sh <= tx_data;
                                sda_oe <= ~tx_data[7];
                            end
                        end
                    WR_ACK:
                        if (scl_f) begin
                            state <= WR_BYTE;
                            sda_oe <= 1'b0;
                        end
                    RD_BYTE:
                        if (scl_f) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                state <= RD_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                sh <= {sh[6:0], 1'b0};
                                sda_oe <= ~sh[6];
                            end
                        end
                    RD_ACK:
                        if (scl_r) ack <= sda_s;
                        else if (scl_f) begin
                            if (ack == I2C_NACK) state <= IGNORE;
                            else begin
                                state <= RD_BYTE;
                                sh <= tx_data;
                                sda_oe <= ~tx_data[7];
                            end
                        end
                    default: ;
                endcase
        end
endmodule
